axi4_lite_reg_slave: RTL

- AXI4-Lite responder with a full write path (AW/W/B) and read path (AR/R) in front of a small 32-bit register file.
- It is the far end of our AXI4_Lite_Master: it completes the master's write transactions and serves read-back of the same registers.
- Register contents are also exported flat, so benches can check them directly.

---
 rtl/axi4_lite_pkg.sv | 21 ++
 rtl/axi4_lite_regfile.sv | 50 +++++
 rtl/axi4_lite_reg_slave.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_pkg.sv
// Shared types for the AXI4-Lite register responder: response codes and
// the write/read channel FSM state encodings.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_COMMIT,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_regfile.sv
// Word register file behind the AXI4-Lite responder: one synchronous write
// port, one combinational read port and a flat export of every register.
module axi4_lite_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4,
    parameter int IDX_W      = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           we,
    input  logic [IDX_W-1:0]               widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [IDX_W-1:0]               ridx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    // Storage: cleared on reset, written at the selected index when we is high.
    // Indices with no matching register are simply not written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                mem[k] <= '0;
            end
        end else if (we) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (widx == IDX_W'(k)) begin
                    mem[k] <= wdata;
                end
            end
        end
    end

    // Combinational read; an index with no register reads as zero.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ridx == IDX_W'(k)) begin
                rdata = mem[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = mem[g];
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite responder in front of a small register file. Write and read
// channels run as two independent FSMs; all handshake outputs are registered.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// WR_IDLE   | collecting AW and W (any order); each READY drops after its beat
// WR_COMMIT | both beats held; register written and BVALID raised next edge
// WR_RESP   | BVALID/BRESP held until BREADY, then back to WR_IDLE
// RD_IDLE   | ARREADY high; AR handshake latches RDATA/RRESP and raises RVALID
// RD_DATA   | RVALID/RDATA/RRESP held until RREADY, then back to RD_IDLE
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    // True when the word index addresses an implemented register.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        idx_ok = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (idx == IDX_W'(k)) begin
                idx_ok = 1'b1;
            end
        end
    endfunction

    // Byte offset within a word has no meaning for word registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    wr_state_t             wr_state, wr_state_n;
    logic                  aw_done, aw_done_n;
    logic                  w_done, w_done_n;
    logic [IDX_W-1:0]      aw_idx, aw_idx_n;
    logic [DATA_WIDTH-1:0] w_data, w_data_n;
    logic                  awready, awready_n;
    logic                  wready, wready_n;
    logic                  bvalid, bvalid_n;
    resp_t                 bresp, bresp_n;

    rd_state_t             rd_state, rd_state_n;
    logic                  arready, arready_n;
    logic                  rvalid, rvalid_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    resp_t                 rresp, rresp_n;

    logic                  rf_we;
    logic [IDX_W-1:0]      rf_ridx;
    logic [DATA_WIDTH-1:0] rf_rdata;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;

    assign aw_hs   = AWVALID & awready;
    assign w_hs    = WVALID & wready;
    assign ar_hs   = ARVALID & arready;
    assign rf_ridx = ARADDR[ADDR_WIDTH-1:2];

    axi4_lite_regfile #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W)
    ) u_regfile (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .we    (rf_we),
        .widx  (aw_idx),
        .wdata (w_data),
        .ridx  (rf_ridx),
        .rdata (rf_rdata),
        .regs_o(regs_o)
    );

    // Write channel next-state: capture AW/W independently, commit, respond.
    always_comb begin
        wr_state_n = wr_state;
        aw_done_n  = aw_done;
        w_done_n   = w_done;
        aw_idx_n   = aw_idx;
        w_data_n   = w_data;
        awready_n  = awready;
        wready_n   = wready;
        bvalid_n   = bvalid;
        bresp_n    = bresp;
        rf_we      = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_idx_n  = AWADDR[ADDR_WIDTH-1:2];
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    w_data_n = WDATA;
                    w_done_n = 1'b1;
                end
                // READY rises on the first edge after reset and stays up
                // until its own beat has been taken.
                awready_n = !aw_done_n;
                wready_n  = !w_done_n;
                if (aw_done_n && w_done_n) begin
                    wr_state_n = WR_COMMIT;
                    aw_done_n  = 1'b0;
                    w_done_n   = 1'b0;
                    awready_n  = 1'b0;
                    wready_n   = 1'b0;
                end
            end
            WR_COMMIT: begin
                rf_we      = idx_ok(aw_idx);
                bvalid_n   = 1'b1;
                bresp_n    = idx_ok(aw_idx) ? RESP_OKAY : RESP_SLVERR;
                wr_state_n = WR_RESP;
            end
            WR_RESP: begin
                if (BREADY) begin
                    bvalid_n   = 1'b0;
                    awready_n  = 1'b1;
                    wready_n   = 1'b1;
                    wr_state_n = WR_IDLE;
                end
            end
            default: begin
                wr_state_n = WR_IDLE;
            end
        endcase
    end

    // Write channel registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state <= WR_IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            aw_idx   <= '0;
            w_data   <= '0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            bvalid   <= 1'b0;
            bresp    <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_n;
            aw_done  <= aw_done_n;
            w_done   <= w_done_n;
            aw_idx   <= aw_idx_n;
            w_data   <= w_data_n;
            awready  <= awready_n;
            wready   <= wready_n;
            bvalid   <= bvalid_n;
            bresp    <= bresp_n;
        end
    end

    // Read channel next-state. RDATA is taken from the regfile's current
    // contents, so a commit on the same edge is not visible to this read.
    always_comb begin
        rd_state_n = rd_state;
        arready_n  = arready;
        rvalid_n   = rvalid;
        rdata_n    = rdata_q;
        rresp_n    = rresp;
        case (rd_state)
            RD_IDLE: begin
                arready_n = 1'b1;
                if (ar_hs) begin
                    rdata_n    = idx_ok(rf_ridx) ? rf_rdata : '0;
                    rresp_n    = idx_ok(rf_ridx) ? RESP_OKAY : RESP_SLVERR;
                    rvalid_n   = 1'b1;
                    arready_n  = 1'b0;
                    rd_state_n = RD_DATA;
                end
            end
            RD_DATA: begin
                if (RREADY) begin
                    rvalid_n   = 1'b0;
                    arready_n  = 1'b1;
                    rd_state_n = RD_IDLE;
                end
            end
            default: begin
                rd_state_n = RD_IDLE;
            end
        endcase
    end

    // Read channel registers.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state <= RD_IDLE;
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rdata_q  <= '0;
            rresp    <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_n;
            arready  <= arready_n;
            rvalid   <= rvalid_n;
            rdata_q  <= rdata_n;
            rresp    <= rresp_n;
        end
    end

    assign AWREADY = awready;
    assign WREADY  = wready;
    assign BVALID  = bvalid;
    assign BRESP   = bresp;
    assign ARREADY = arready;
    assign RVALID  = rvalid;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp;

endmodule
